// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter and timed transaction sequencer for a shared i2c_master.
// Every phase is parameter-timed because the master gives no busy/done feedback.
module i2c_txn_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int TXN_CYCLES  = 20,
    parameter int STOP_CYCLES = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic                 busy,
    output logic                 m_start,
    output logic                 m_stop,
    output logic                 m_rw,
    output logic [6:0]           m_addr,
    output logic [7:0]           m_w_data
);

    localparam int MAX_CYC = (TXN_CYCLES > STOP_CYCLES) ? TXN_CYCLES : STOP_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam int OW      = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] owner_q, owner_d;
    logic          m_rw_q, m_rw_d;
    logic [6:0]    m_addr_q, m_addr_d;
    logic [7:0]    m_w_data_q, m_w_data_d;

    logic          sel_valid;
    int unsigned   sel;
    int unsigned   cand;

    // Search starts one past the last owner, so the previous owner ranks last.
    always_comb begin
        sel_valid = 1'b0;
        sel       = 0;
        cand      = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(owner_q) + k) % NUM_REQ;
            if (!sel_valid && req[OW'(cand)]) begin
                sel_valid = 1'b1;
                sel       = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        m_rw_d     = m_rw_q;
        m_addr_d   = m_addr_q;
        m_w_data_d = m_w_data_q;
        case (state_q)
            S_IDLE: begin
                if (sel_valid) begin
                    state_d    = S_XFER;
                    cnt_d      = '0;
                    owner_d    = OW'(sel);
                    m_rw_d     = req_rw[sel];
                    m_addr_d   = req_addr[7*sel +: 7];
                    m_w_data_d = req_data[8*sel +: 8];
                end
            end
            S_XFER: begin
                if (cnt_q == CW'(TXN_CYCLES - 1)) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == CW'(STOP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            owner_q    <= OW'(NUM_REQ - 1);
            m_rw_q     <= 1'b0;
            m_addr_q   <= '0;
            m_w_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            m_rw_q     <= m_rw_d;
            m_addr_q   <= m_addr_d;
            m_w_data_q <= m_w_data_d;
        end
    end

    always_comb begin
        gnt  = '0;
        done = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            gnt[i]  = (state_q == S_XFER) && (cnt_q == '0) && (owner_q == OW'(i));
            done[i] = (state_q == S_STOP) && (cnt_q == CW'(STOP_CYCLES - 1))
                      && (owner_q == OW'(i));
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign m_start  = (state_q == S_XFER);
    assign m_stop   = (state_q == S_STOP);
    assign m_rw     = m_rw_q;
    assign m_addr   = m_addr_q;
    assign m_w_data = m_w_data_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench for i2c_txn_arbiter: a transaction-level model predicts grants,
// and a negedge monitor checks pulses, phase windows and latched fields each cycle.
module tb_i2c_txn_arbiter;

    localparam int N    = 2;
    localparam int TXN  = 20;
    localparam int STOP = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   req_rw;
    logic [7*N-1:0] req_addr;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           busy, m_start, m_stop, m_rw;
    logic [6:0]     m_addr;
    logic [7:0]     m_w_data;

    i2c_txn_arbiter #(
        .NUM_REQ    (N),
        .TXN_CYCLES (TXN),
        .STOP_CYCLES(STOP)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .req_rw  (req_rw),
        .req_addr(req_addr),
        .req_data(req_data),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .m_start (m_start),
        .m_stop  (m_stop),
        .m_rw    (m_rw),
        .m_addr  (m_addr),
        .m_w_data(m_w_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned owner;
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  data;
        int          g;
    } txn_t;

    txn_t gnt_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rst_edge = -1;

    // Model state: transaction-level arbitration with arithmetic timing windows.
    int unsigned  last_owner = N - 1;
    int           free_edge  = 0;
    logic [N-1:0] granted;

    int raise_pct   = 0;
    int hold_pct    = 0;
    bit rand_fields = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        granted = '0;
        if (reset) begin
            gnt_q.delete();
            rst_edge   = cyc;
            last_owner = N - 1;
            free_edge  = cyc + 1;
        end else if (cyc >= free_edge && req != '0) begin
            bit found = 0;
            for (int k = 1; k <= N; k++) begin
                int unsigned idx = (last_owner + k) % N;
                if (!found && req[idx]) begin
                    txn_t t;
                    found      = 1;
                    t.owner    = idx;
                    t.rw       = req_rw[idx];
                    t.addr     = req_addr[7*idx +: 7];
                    t.data     = req_data[8*idx +: 8];
                    t.g        = cyc;
                    gnt_q.push_back(t);
                    last_owner = idx;
                    free_edge  = cyc + TXN + STOP + 1;
                    granted[idx] = 1'b1;
                end
            end
        end
    endtask

    task automatic update_inputs();
        for (int i = 0; i < N; i++) begin
            if (granted[i]) begin
                if ($urandom_range(99) >= hold_pct) req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(99) < raise_pct) begin
                req[i] = 1'b1;
            end
        end
        if (rand_fields) begin
            req_rw   = N'($urandom);
            req_addr = (7*N)'({$urandom, $urandom});
            req_data = (8*N)'({$urandom, $urandom});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        update_inputs();
    endtask

    task automatic wait_grant(input int unsigned who);
        bit got = 0;
        for (int n = 0; n < 80 && !got; n++) begin
            tick();
            if (granted[who]) got = 1;
        end
        chk("grant_timeout", 32'(got), 32'd1);
    endtask

    // Monitor: expected behaviour follows from the most recent popped grant.
    txn_t        act;
    bit          act_valid = 0;
    logic [15:0] exp_fld   = '0;

    initial begin
        forever begin
            logic [N-1:0] eg, ed;
            bit in_x, in_s;
            @(negedge clk);
            if (rst_edge == cyc) begin
                act_valid = 0;
                exp_fld   = '0;
            end
            eg = '0;
            if (gnt_q.size() > 0 && gnt_q[0].g == cyc) begin
                act       = gnt_q.pop_front();
                act_valid = 1;
                eg        = N'(1) << act.owner;
                exp_fld   = {act.rw, act.addr, act.data};
            end
            in_x = act_valid && cyc >= act.g && cyc < act.g + TXN;
            in_s = act_valid && cyc >= act.g + TXN && cyc < act.g + TXN + STOP;
            ed   = (act_valid && cyc == act.g + TXN + STOP - 1) ? (N'(1) << act.owner) : '0;
            chk("gnt", 32'(gnt), 32'(eg));
            chk("done", 32'(done), 32'(ed));
            chk("busy_start_stop", {29'd0, busy, m_start, m_stop},
                {29'd0, in_x || in_s, in_x, in_s});
            chk("fields", {16'd0, m_rw, m_addr, m_w_data}, {16'd0, exp_fld});
        end
    end

    initial begin
        reset = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_data = '0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (10) tick();

        // Single write, then disturb the owner's fields once granted.
        req[0] = 1'b1; req_rw[0] = 1'b0; req_addr[6:0] = 7'h55; req_data[7:0] = 8'hAA;
        wait_grant(0);
        req_addr[6:0] = 7'h12; req_data[7:0] = 8'h34;
        repeat (30) tick();

        // Simultaneous requests straight after reset.
        reset = 1'b1; tick(); reset = 1'b0;
        req = 2'b11; req_rw = 2'b10;
        req_addr = {7'h55, 7'h55}; req_data = {8'h01, 8'hAA};
        repeat (60) tick();

        // Continuous contention for six transactions.
        hold_pct = 100; req = 2'b11;
        repeat (6 * 26) tick();
        hold_pct = 0; req = '0;
        repeat (30) tick();

        // Reset in the middle of a transfer.
        req[0] = 1'b1;
        wait_grant(0);
        repeat (10) tick();
        reset = 1'b1; req = '0; tick(); reset = 1'b0;
        req[1] = 1'b1;
        wait_grant(1);
        req = 2'b11;
        wait_grant(0);
        repeat (60) tick();

        // Randomized traffic with occasional resets.
        raise_pct = 20; hold_pct = 30; rand_fields = 1;
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(599) == 0);
            tick();
        end
        reset = 1'b0;

        raise_pct = 0; hold_pct = 0; req = '0;
        repeat (40) tick();
        chk("pending_grants", 32'(gnt_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
